alu_operand_sequencer: RTL

Upstream/downstream companion to the bit-serial ALU: holds a small register bank, serializes two source registers LSB-first onto the ALU's `a`/`b` inputs, deserializes the ALU's `y` stream back into a destination register, and captures the ALU's final carry/compare bit `c` into a flag. It also sequences the ALU's per-operation reset and opcode, so a host only issues `start` and waits for `done`.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_seq_regbank.sv | 51 +++++
 rtl/alu_operand_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the bit-serial ALU operand sequencer.
package alu_seq_pkg;
    localparam int W_DEF     = 8;
    localparam int NREGS_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_SHIFT,
        S_DONE
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MOVB = 3'd5;
    localparam logic [2:0] OP_MOVA = 3'd6;
    localparam logic [2:0] OP_SHL  = 3'd7;
endpackage

// File: rtl/alu_seq_regbank.sv
// Register bank: host write port, writeback port, three read ports.
// ALU_SEQ_R0_ZERO_EN makes R0 a hardwired zero.
module alu_seq_regbank
    import alu_seq_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     host_we_i,
    input  logic [$clog2(NREGS)-1:0] host_addr_i,
    input  logic [W-1:0]             host_data_i,
    input  logic                     wb_en_i,
    input  logic [$clog2(NREGS)-1:0] wb_addr_i,
    input  logic [W-1:0]             wb_data_i,
    input  logic [$clog2(NREGS)-1:0] ra_addr_i,
    output logic [W-1:0]             ra_data_o,
    input  logic [$clog2(NREGS)-1:0] rb_addr_i,
    output logic [W-1:0]             rb_data_o,
    input  logic [$clog2(NREGS)-1:0] rd_addr_i,
    output logic [W-1:0]             rd_data_o
);
    localparam int AW = $clog2(NREGS);
`ifdef ALU_SEQ_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic [W-1:0] regs_q [NREGS];

    function automatic logic is_r0z(input logic [AW-1:0] a);
        return R0Z && (a == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (host_we_i && !is_r0z(host_addr_i))
                regs_q[host_addr_i] <= host_data_i;
            if (wb_en_i && !is_r0z(wb_addr_i))
                regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    assign ra_data_o = is_r0z(ra_addr_i) ? '0 : regs_q[ra_addr_i];
    assign rb_data_o = is_r0z(rb_addr_i) ? '0 : regs_q[rb_addr_i];
    assign rd_data_o = is_r0z(rd_addr_i) ? '0 : regs_q[rd_addr_i];
endmodule

// File: rtl/alu_operand_sequencer.sv
// Serializes two registers into a bit-serial ALU and deserializes the result.
// Optional hardwired-zero R0 via ALU_SEQ_R0_ZERO_EN.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [$clog2(NREGS)-1:0] rs2,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic                     ld_en,
    input  logic [$clog2(NREGS)-1:0] ld_addr,
    input  logic [W-1:0]             ld_data,
    input  logic [$clog2(NREGS)-1:0] rd_addr,
    output logic [W-1:0]             rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     cflag,
    output logic                     alu_rst_n,
    output logic [2:0]               alu_op,
    output logic                     alu_a,
    output logic                     alu_b,
    input  logic                     alu_y,
    input  logic                     alu_c
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_e          state_q, state_d;
    logic [2:0]      op_q;
    logic [AW-1:0]   rs1_q, rs2_q, rd_q;
    logic [W-1:0]    a_q, b_q, res_q;
    logic [CW-1:0]   cnt_q;
    logic            cflag_q;
    logic [W-1:0]    ra_data, rb_data;

    alu_seq_regbank #(.W(W), .NREGS(NREGS)) u_regbank (
        .clk         (clk),
        .rst         (rst),
        .host_we_i   (ld_en && (state_q == S_IDLE)),
        .host_addr_i (ld_addr),
        .host_data_i (ld_data),
        .wb_en_i     (state_q == S_DONE),
        .wb_addr_i   (rd_q),
        .wb_data_i   (res_q),
        .ra_addr_i   (rs1_q),
        .ra_data_o   (ra_data),
        .rb_addr_i   (rs2_q),
        .rb_data_o   (rb_data),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        done      = 1'b0;
        alu_rst_n = rst;
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_PREP;
            end
            S_PREP: begin
                alu_rst_n = 1'b0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                alu_a = a_q[0];
                alu_b = b_q[0];
                if (cnt_q == CW'(W - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        rd_q  <= rd;
                    end
                end
                S_PREP: begin
                    a_q   <= ra_data;
                    b_q   <= rb_data;
                    cnt_q <= '0;
                end
                S_SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= {alu_y, res_q[W-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_DONE: cflag_q <= alu_c;
                default: ;
            endcase
        end
    end

    assign cflag  = cflag_q;
    assign alu_op = op_q;
endmodule
